// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and wait-state sequencer for a single-port BRAM.
// Requesters see a req/ack handshake; all BRAM enable/write timing lives here.
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              grant_id,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [2:0] CntLast = 3'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              bram_en_q, bram_en_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic              gnt;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    bram_en_d    = bram_en_q;
    bram_we_d    = bram_we_q;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    // Port 1 wins when alone, or on contention if port 0 had the last access.
    gnt          = req1 && (!req0 || !last_grant_q);

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d      = StAccess;
          grant_d      = gnt;
          cnt_d        = 3'd0;
          we_d         = gnt ? we1 : we0;
          bram_en_d    = 1'b1;
          bram_we_d    = gnt ? we1 : we0;
          bram_addr_d  = gnt ? addr1 : addr0;
          bram_wdata_d = gnt ? wdata1 : wdata0;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CntLast) begin
          state_d   = StDone;
          bram_en_d = 1'b0;
          bram_we_d = 1'b0;
          ack0_d    = !grant_q;
          ack1_d    = grant_q;
          if (!we_q) begin
            if (grant_q) rdata1_d = bram_rdata;
            else         rdata0_d = bram_rdata;
          end
        end
      end
      StDone: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign busy       = (state_q != StIdle);
  assign grant_id   = grant_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;

endmodule
